// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: command queue feeding a LOAD/EXEC/CAPT/RESP sequencer for a shift datapath.
// Define SHIFT_SEQ_OPCNT_EN to add the op_count_o completed-response counter.
module shift_seq_ctrl #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [3:0] cmd_data_i,
    input  logic [1:0] cmd_ch_i,
    input  logic [1:0] cmd_sh_i,
    output logic       dp_load_o,
    output logic [3:0] dp_in_o,
    output logic [1:0] dp_ch_o,
    output logic [1:0] dp_sh_o,
    output logic       dp_rg_o,
    input  logic [3:0] dp_out_i,
    output logic       rsp_valid_o,
    input  logic       rsp_ready_i,
    output logic [3:0] rsp_data_o,
    output logic       busy_o
`ifdef SHIFT_SEQ_OPCNT_EN
    ,
    output logic [7:0] op_count_o
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {IDLE, LOAD, EXEC, CAPT, RESP} state_e;

    state_e        state_q;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q, rd_q, wr_d, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    wch_q, wsh_q;
    logic          dp_load_q, dp_rg_q, rsp_valid_q;
    logic [3:0]    dp_in_q, rsp_data_q;
    logic [1:0]    dp_ch_q, dp_sh_q;
    logic          push, pop;
    logic [7:0]    head;

    assign cmd_ready_o = cnt_q != CW'(FIFO_DEPTH);
    assign push        = cmd_valid_i && cmd_ready_o;
    // Pop uses registered occupancy, so a fresh entry is only seen one cycle later.
    assign pop         = (state_q == IDLE) && (cnt_q != '0);
    assign head        = mem_q[rd_q];

    always_comb begin
        wr_d  = push ? wr_q + AW'(1) : wr_q;
        rd_d  = pop ? rd_q + AW'(1) : rd_q;
        cnt_d = cnt_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_q] <= {cmd_data_i, cmd_ch_i, cmd_sh_i};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            wch_q       <= '0;
            wsh_q       <= '0;
            dp_load_q   <= 1'b0;
            dp_rg_q     <= 1'b0;
            dp_in_q     <= '0;
            dp_ch_q     <= '0;
            dp_sh_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (pop) begin
                    state_q   <= LOAD;
                    wch_q     <= head[3:2];
                    wsh_q     <= head[1:0];
                    dp_load_q <= 1'b1;
                    dp_rg_q   <= 1'b0;
                    dp_in_q   <= head[7:4];
                    dp_ch_q   <= 2'b00;
                    dp_sh_q   <= 2'b00;
                end
                LOAD: begin
                    state_q <= EXEC;
                    dp_rg_q <= 1'b1;
                    dp_ch_q <= wch_q;
                    dp_sh_q <= wsh_q;
                end
                EXEC: begin
                    state_q   <= CAPT;
                    dp_load_q <= 1'b0;
                end
                CAPT: begin
                    state_q     <= RESP;
                    rsp_data_q  <= dp_out_i;
                    rsp_valid_q <= 1'b1;
                end
                RESP: if (rsp_ready_i) begin
                    state_q     <= IDLE;
                    rsp_valid_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dp_load_o   = dp_load_q;
    assign dp_rg_o     = dp_rg_q;
    assign dp_in_o     = dp_in_q;
    assign dp_ch_o     = dp_ch_q;
    assign dp_sh_o     = dp_sh_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign busy_o      = (state_q != IDLE) || (cnt_q != '0);

`ifdef SHIFT_SEQ_OPCNT_EN
    logic [7:0] opcnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) opcnt_q <= '0;
        else if (state_q == RESP && rsp_ready_i) opcnt_q <= opcnt_q + 8'd1;
    end

    assign op_count_o = opcnt_q;
`endif
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb_shift_seq_ctrl: randomized scenarios for shift_seq_ctrl, checked against an in-order result scoreboard.
module tb_shift_seq_ctrl;
    logic       clk_i = 1'b0;
    logic       rst_n = 1'b1;
    logic       cmd_valid = 1'b0, rsp_ready = 1'b0;
    logic [3:0] cmd_data = '0;
    logic [1:0] cmd_ch = '0, cmd_sh = '0;
    logic       cmd_ready_o, dp_load_o, dp_rg_o, rsp_valid_o, busy_o;
    logic [3:0] dp_in_o, rsp_data_o, dp_reg = '0;
    logic [1:0] dp_ch_o, dp_sh_o;
`ifdef SHIFT_SEQ_OPCNT_EN
    logic [7:0] op_count_o;
`endif
    int checks = 0, failures = 0, cyc = 0;
    logic [3:0] exp_q[$], got_q[$];
    int got_cyc[$];

    shift_seq_ctrl #(.FIFO_DEPTH(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o),
        .cmd_data_i(cmd_data), .cmd_ch_i(cmd_ch), .cmd_sh_i(cmd_sh),
        .dp_load_o(dp_load_o), .dp_in_o(dp_in_o), .dp_ch_o(dp_ch_o), .dp_sh_o(dp_sh_o),
        .dp_rg_o(dp_rg_o), .dp_out_i(dp_reg),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data_o),
        .busy_o(busy_o)
`ifdef SHIFT_SEQ_OPCNT_EN
        , .op_count_o(op_count_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // ch: 00 pass, 01 shift left, 10 shift right, 11 rotate left.
    function automatic logic [3:0] xform(logic [3:0] a, logic [1:0] ch, logic [1:0] sh);
        int v = a;
        int s = sh;
        case (ch)
            2'd0:    return a;
            2'd1:    return 4'((v << s) % 16);
            2'd2:    return 4'(v >> s);
            default: return 4'(((v << s) | (v >> (4 - s))) % 16);
        endcase
    endfunction

    // External datapath: loads the operand, then applies the operation to its register.
    always @(posedge clk_i) if (dp_load_o) dp_reg <= dp_rg_o ? xform(dp_reg, dp_ch_o, dp_sh_o) : dp_in_o;

    task automatic tick();
        if (cmd_valid && cmd_ready_o) exp_q.push_back(xform(cmd_data, cmd_ch, cmd_sh));
        if (rsp_valid_o && rsp_ready) begin
            got_q.push_back(rsp_data_o);
            got_cyc.push_back(cyc);
        end
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic drain(input int budget, output bit ok);
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < budget && (busy_o || rsp_valid_o); i++) tick();
        ok = !busy_o && !rsp_valid_o;
    endtask

    task automatic clear();
        exp_q.delete();
        got_q.delete();
        got_cyc.delete();
    endtask

    task automatic rand_cmd();
        cmd_data = 4'($urandom);
        cmd_ch   = 2'($urandom);
        cmd_sh   = 2'($urandom);
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({cmd_ready_o, dp_load_o, dp_in_o, dp_ch_o, dp_sh_o, dp_rg_o, rsp_valid_o, rsp_data_o, busy_o} !== {1'b1, 1'b0, 4'h0, 2'b00, 2'b00, 1'b0, 1'b0, 4'h0, 1'b0}) begin
            failures++;
            $display("FAIL reset_values got rdy=%b ld=%b in=%h ch=%b sh=%b rg=%b rv=%b rd=%h busy=%b", cmd_ready_o, dp_load_o, dp_in_o, dp_ch_o, dp_sh_o, dp_rg_o, rsp_valid_o, rsp_data_o, busy_o);
        end
        @(posedge clk_i);
        #1;
        rst_n = 1'b1;
        checks++;
        if (busy_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_release busy=%b rdy=%b want busy=0 rdy=1", busy_o, cmd_ready_o);
        end
    endtask

    task automatic test_single();
        int pop_cyc, rv_cyc;
        clear();
        rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_data = 4'b0010; cmd_ch = 2'b01; cmd_sh = 2'b01;
        tick();
        cmd_valid = 1'b0;
        checks++;
        if (exp_q.size() != 1 || busy_o !== 1'b1) begin
            failures++;
            $display("FAIL first_accept accepted=%0d busy=%b want 1 and 1", exp_q.size(), busy_o);
        end
        pop_cyc = cyc;
        tick();
        checks++;
        if ({dp_load_o, dp_rg_o, dp_in_o, dp_ch_o, dp_sh_o} !== {1'b1, 1'b0, 4'b0010, 2'b00, 2'b00}) begin
            failures++;
            $display("FAIL load_cycle ld=%b rg=%b in=%b ch=%b sh=%b want 1 0 0010 00 00", dp_load_o, dp_rg_o, dp_in_o, dp_ch_o, dp_sh_o);
        end
        tick();
        checks++;
        if ({dp_load_o, dp_rg_o, dp_in_o, dp_ch_o, dp_sh_o} !== {1'b1, 1'b1, 4'b0010, 2'b01, 2'b01}) begin
            failures++;
            $display("FAIL exec_cycle ld=%b rg=%b in=%b ch=%b sh=%b want 1 1 0010 01 01", dp_load_o, dp_rg_o, dp_in_o, dp_ch_o, dp_sh_o);
        end
        tick();
        checks++;
        if ({dp_load_o, dp_in_o, dp_ch_o, dp_sh_o, rsp_valid_o} !== {1'b0, 4'b0010, 2'b01, 2'b01, 1'b0}) begin
            failures++;
            $display("FAIL capt_hold ld=%b in=%b ch=%b sh=%b rv=%b want 0 0010 01 01 0", dp_load_o, dp_in_o, dp_ch_o, dp_sh_o, rsp_valid_o);
        end
        tick();
        rv_cyc = cyc;
        checks++;
        if (rsp_valid_o !== 1'b1 || rsp_data_o !== 4'b0100 || rv_cyc - pop_cyc != 4) begin
            failures++;
            $display("FAIL single_rsp rv=%b data=%b lat=%0d want 1 0100 4", rsp_valid_o, rsp_data_o, rv_cyc - pop_cyc);
        end
        rsp_ready = 1'b1;
        tick();
        checks++;
        if (rsp_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL single_done rv=%b busy=%b want 0 0", rsp_valid_o, busy_o);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        clear();
        rsp_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            rand_cmd();
            cmd_ch = 2'(i);
            cmd_valid = 1'b1;
            tick();
        end
        drain(100, ok);
        checks++;
        if (!ok || got_q.size() != 3) begin
            failures++;
            $display("FAIL b2b_count got=%0d drained=%0d want 3 1", got_q.size(), ok);
        end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL b2b_data[%0d] got=%h want=%h", i, got_q[i], exp_q[i]);
            end
        end
        for (int i = 1; i < 3 && i < got_cyc.size(); i++) begin
            checks++;
            if (got_cyc[i] - got_cyc[i-1] != 5) begin
                failures++;
                $display("FAIL b2b_spacing[%0d] got=%0d want=5", i, got_cyc[i] - got_cyc[i-1]);
            end
        end
    endtask

    task automatic test_full();
        bit ok, stable;
        clear();
        rsp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            rand_cmd();
            cmd_valid = 1'b1;
            tick();
        end
        cmd_valid = 1'b0;
        checks++;
        if (exp_q.size() != 5 || cmd_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL full_accept accepted=%0d rdy=%b want 5 0", exp_q.size(), cmd_ready_o);
        end
        stable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (rsp_valid_o !== 1'b1 || rsp_data_o !== exp_q[0]) stable = 1'b0;
            tick();
        end
        checks++;
        if (!stable) begin
            failures++;
            $display("FAIL full_hold rv=%b data=%h want 1 %h", rsp_valid_o, rsp_data_o, exp_q[0]);
        end
        drain(200, ok);
        checks++;
        if (!ok || got_q.size() != 5) begin
            failures++;
            $display("FAIL full_drain got=%0d drained=%0d want 5 1", got_q.size(), ok);
        end
        for (int i = 0; i < 5 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL full_data[%0d] got=%h want=%h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_exec();
        bit saw;
        clear();
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_cmd();
            cmd_valid = 1'b1;
            tick();
        end
        cmd_valid = 1'b0;
        checks++;
        if (dp_load_o !== 1'b1 || dp_rg_o !== 1'b1 || cmd_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_exec ld=%b rg=%b rdy=%b want 1 1 1", dp_load_o, dp_rg_o, cmd_ready_o);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({cmd_ready_o, dp_load_o, dp_in_o, dp_ch_o, dp_sh_o, dp_rg_o, rsp_valid_o, rsp_data_o, busy_o} !== {1'b1, 1'b0, 4'h0, 2'b00, 2'b00, 1'b0, 1'b0, 4'h0, 1'b0}) begin
            failures++;
            $display("FAIL reset_exec_values rdy=%b ld=%b in=%h ch=%b sh=%b rg=%b rv=%b rd=%h busy=%b", cmd_ready_o, dp_load_o, dp_in_o, dp_ch_o, dp_sh_o, dp_rg_o, rsp_valid_o, rsp_data_o, busy_o);
        end
        #1 rst_n = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid_o || busy_o) saw = 1'b1;
            tick();
        end
        checks++;
        if (saw || got_q.size() != 0) begin
            failures++;
            $display("FAIL reset_discard activity=%b rsps=%0d want 0 0", saw, got_q.size());
        end
    endtask

    task automatic test_random(input int n, input string tag);
        bit ok;
        clear();
        for (int i = 0; i < 2000 && exp_q.size() < n; i++) begin
            rand_cmd();
            cmd_valid = 1'($urandom_range(0, 3) != 0);
            rsp_ready = 1'($urandom_range(0, 2) != 0);
            tick();
        end
        drain(300, ok);
        checks++;
        if (!ok || exp_q.size() != n || got_q.size() != n) begin
            failures++;
            $display("FAIL %s_count accepted=%0d got=%0d drained=%0d want %0d %0d 1", tag, exp_q.size(), got_q.size(), ok, n, n);
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL %s_data[%0d] got=%h want=%h", tag, i, got_q[i], exp_q[i]);
            end
        end
    endtask

`ifdef SHIFT_SEQ_OPCNT_EN
    task automatic test_opcnt();
        bit ok;
        clear();
        rst_n = 1'b0;
        #1;
        checks++;
        if (op_count_o !== 8'd0) begin
            failures++;
            $display("FAIL opcnt_reset got=%0d want=0", op_count_o);
        end
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3000 && exp_q.size() < 257; i++) begin
            rand_cmd();
            cmd_valid = 1'b1;
            rsp_ready = 1'b1;
            tick();
        end
        drain(100, ok);
        checks++;
        if (!ok || got_q.size() != 257 || op_count_o !== 8'd1) begin
            failures++;
            $display("FAIL opcnt_wrap got=%0d rsps=%0d want op_count=1 rsps=257", op_count_o, got_q.size());
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_reset_exec();
        test_random(9, "wrap");
        test_random(40, "random");
`ifdef SHIFT_SEQ_OPCNT_EN
        test_opcnt();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
